uart_rx_sipo: RTL and testbench

- Serial-in, parallel-out receive stage. It consumes the 10-bit idle-high frame stream that the transmit PISO shifter produces.
- It oversamples the line on the system clock, detects the start bit, and recovers 8 data bits.
- It checks the stop bit and presents each byte on a valid/ack handshake to the downstream microprocessor I/O logic.
- It flags framing errors and overruns.

---
 rtl/uart_rx_sipo.sv | 141 ++++++++++++++
 tb/tb_uart_rx_sipo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sipo.sv
// UART receive stage: oversamples an idle-high 10-bit frame (start, data[7..0] MSB first, stop)
// and hands each byte to the consumer on a valid/ack handshake with framing and overrun flags.
module uart_rx_sipo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       data_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t           state;
    logic             rx_p0;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       sr;

    // Two-flop synchronizer; reset to the idle level so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= serial_in;
            rx_s  <= rx_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            cnt           <= '0;
            idx           <= 3'd0;
            sr            <= 8'h00;
            data_out      <= 8'h00;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            // An ack retires the held byte; a delivery later in this block overrides it
            if (data_ack) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (cnt == CNT_HALF_END) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                            idx   <= 3'd0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt == CNT_BIT_END) begin
                        cnt <= '0;
                        sr  <= {sr[6:0], rx_s};
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    if (cnt == CNT_BIT_END) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_out   <= sr;
                            data_valid <= 1'b1;
                            if (data_valid && !data_ack) begin
                                overrun <= 1'b1;
                            end
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                // Hold off until the line is released so a break is not seen as a new start bit
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Testbench for uart_rx_sipo: directed frames plus randomized frames checked against a
// transaction-level model of the receive handshake.
module tb_uart_rx_sipo;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic       data_ack;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int fe_cnt = 0;

    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovr;

    uart_rx_sipo #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .data_ack     (data_ack),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .framing_error(framing_error),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (framing_error) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_data"},  32'(data_out),   32'(exp_data));
        check({tag, "_valid"}, 32'(data_valid), 32'(exp_valid));
        check({tag, "_ovr"},   32'(overrun),    32'(exp_ovr));
    endtask

    // Model: a good stop bit delivers, overwriting an unacked byte sets overrun
    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            if (exp_valid) exp_ovr = 1'b1;
            exp_data  = b;
            exp_valid = 1'b1;
        end
    endtask

    task automatic model_ack();
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
    endtask

    initial begin
        int         spur;
        int         lat;
        int         f0;
        int         seen;
        logic [7:0] b;
        logic       stop;

        serial_in = 1'b1;
        data_ack  = 1'b0;
        reset     = 1'b1;
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",  32'(data_out),      32'h00);
        check("rst_valid", 32'(data_valid),    32'h0);
        check("rst_fe",    32'(framing_error), 32'h0);
        check("rst_ovr",   32'(overrun),       32'h0);
        check("rst_busy",  32'(busy),          32'h0);
        reset = 1'b0;

        // Idle line must stay quiet
        spur = 0;
        repeat (200) begin
            @(negedge clk);
            if (data_valid || busy || framing_error || overrun || data_out != 8'h00) spur++;
        end
        check("idle_quiet", 32'(spur), 32'd0);

        // Frame 0xA5 with latency measured from the first edge that sees the line low
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                int n = 0;
                int found = 0;
                while (n < 400 && found == 0) begin
                    @(posedge clk);
                    n++;
                    #1;
                    if (data_valid) found = 1;
                end
                lat = n;
            end
        join
        check("a5_latency", 32'(lat), 32'd155);
        model_frame(8'hA5, 1'b1);
        check_model("a5");
        idle(1);
        ack_pulse();
        model_ack();
        check_model("a5_ack");

        // Short glitch on the line
        f0 = fe_cnt;
        seen = 0;
        serial_in = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy) seen = 1;
        end
        serial_in = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (busy) seen = 1;
        end
        check("glitch_busy_rose", 32'(seen), 32'd1);
        check("glitch_busy_drop", 32'(busy), 32'd0);
        check("glitch_fe", 32'(fe_cnt - f0), 32'd0);
        check_model("glitch");

        // Stop bit low, line held low as a break
        f0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        check("fe_pulses", 32'(fe_cnt - f0), 32'd1);
        check("fe_busy_hold", 32'(busy), 32'd1);
        check_model("fe");
        idle(5);
        check("fe_busy_release", 32'(busy), 32'd0);

        // Back-to-back frames without ack
        send_frame(8'h12, 1'b1);
        model_frame(8'h12, 1'b1);
        check_model("b2b_first");
        send_frame(8'h34, 1'b1);
        model_frame(8'h34, 1'b1);
        check_model("b2b_second");
        idle(3);
        ack_pulse();
        model_ack();
        check_model("b2b_ack");

        // Reset in the middle of a 0xFF frame
        send_bit(1'b0);
        repeat (3) send_bit(1'b1);
        reset = 1'b1;
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        check_model("mid_rst");
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_fe", 32'(framing_error), 32'd0);
        idle(30);
        check_model("post_rst_idle");
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1);
        check_model("post_rst_81");
        idle(2);
        ack_pulse();
        model_ack();

        // Randomized frames, stop bits and acks
        for (int k = 0; k < 24; k++) begin
            b    = 8'($urandom());
            stop = ($urandom_range(0, 5) != 0);
            f0   = fe_cnt;
            check("rnd_idle_busy", 32'(busy), 32'd0);
            send_frame(b, stop);
            serial_in = 1'b1;
            model_frame(b, stop);
            check("rnd_fe", 32'(fe_cnt - f0), stop ? 32'd0 : 32'd1);
            check_model("rnd");
            if ($urandom_range(0, 1) == 1) begin
                ack_pulse();
                model_ack();
                check_model("rnd_ack");
            end
            idle($urandom_range(4, 12));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
